intr_ctl: RTL and testbench

INTR_CTL -- requirements
Module: intr_ctl

---
 rtl/intr_ctl.sv | 155 +++++++++++++++
 tb/tb_intr_ctl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctl.sv
// Eight-source interrupt controller: edge-detected pending bits, mask, fixed priority, IRQ/ack handshake.
// Define INTC_SYNC_EN to insert a 2-flop synchronizer on src ahead of the edge detector.
module intr_ctl #(
    parameter int unsigned MIN_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] src,
    input  logic       mask_we,
    input  logic [7:0] mask_wd,
    input  logic       iack,
    output logic       irq,
    output logic [2:0] cause,
    output logic [7:0] pend,
    output logic [7:0] mask,
    output logic       in_svc
);

    localparam int unsigned NSRC = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned GW   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            iack_q, iack_d;
    logic            irq_q, irq_d;
    logic            in_svc_q, in_svc_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] arm_q, arm_d;
    logic [NSRC-1:0] sync1_q, sync1_d;
    logic [NSRC-1:0] sync2_q, sync2_d;

    logic [NSRC-1:0] src_c;
    logic [NSRC-1:0] edge_c;
    logic [NSRC-1:0] active_c;
    logic [NSRC-1:0] clr_c;
    logic [NSRC-1:0] sel_oh_c;
    logic [CW-1:0]   sel_idx_c;
    logic            iack_rise_c;
    logic            iack_fall_c;

    // Source conditioning; the sync flops stay at reset value when the synchronizer is disabled.
    always_comb begin
        sync1_d = '0;
        sync2_d = '0;
`ifdef INTC_SYNC_EN
        sync1_d = src;
        sync2_d = sync1_q;
        src_c   = sync2_q;
`else
        src_c   = src;
`endif
    end

    // A bit is armed only once raw src has been seen low after reset, so a level held across reset never requests.
    assign arm_d  = arm_q | ~src;
    assign prev_d = src_c;
    assign edge_c = src_c & ~prev_q & arm_q;

    assign active_c    = pend_q & mask_q;
    assign iack_d      = iack;
    assign iack_rise_c = iack & ~iack_q;
    assign iack_fall_c = ~iack & iack_q;

    // Fixed priority: bit 0 wins.
    always_comb begin
        sel_idx_c = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active_c[i]) sel_idx_c = CW'(i);
        end
        sel_oh_c = NSRC'(1) << sel_idx_c;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cause_d = cause_q;
        clr_c   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|active_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (iack_rise_c && (|active_c)) begin
                    state_d = ST_SVC;
                    cause_d = sel_idx_c;
                    clr_c   = sel_oh_c;
                end else if (!(|active_c)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (iack_fall_c) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(MIN_GAP - 1)) state_d = ST_IDLE;
                else                           gap_d   = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // A new edge on the bit being cleared keeps it pending.
        pend_d   = (pend_q & ~clr_c) | edge_c;
        mask_d   = mask_we ? mask_wd : mask_q;
        irq_d    = (state_d == ST_REQ);
        in_svc_d = (state_d == ST_SVC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            mask_q   <= '0;
            cause_q  <= '0;
            gap_q    <= '0;
            iack_q   <= 1'b0;
            irq_q    <= 1'b0;
            in_svc_q <= 1'b0;
            prev_q   <= '0;
            arm_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            cause_q  <= cause_d;
            gap_q    <= gap_d;
            iack_q   <= iack_d;
            irq_q    <= irq_d;
            in_svc_q <= in_svc_d;
            prev_q   <= prev_d;
            arm_q    <= arm_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    assign irq    = irq_q;
    assign cause  = cause_q;
    assign pend   = pend_q;
    assign mask   = mask_q;
    assign in_svc = in_svc_q;

endmodule

// File: tb/tb_intr_ctl.sv
// Scoreboard bench for intr_ctl: stimulus queues expected output snapshots, a negedge monitor compares them.
module tb_intr_ctl;

`ifdef INTC_SYNC_EN
    localparam int PL = 2;
`else
    localparam int PL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_wd;
    logic       iack;
    logic       irq;
    logic [2:0] cause;
    logic [7:0] pend;
    logic [7:0] mask;
    logic       in_svc;

    typedef struct {
        string      name;
        logic       irq;
        logic [7:0] pend;
        logic [7:0] mask;
        logic [2:0] cause;
        logic       in_svc;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mask_exp = 8'h00;

    intr_ctl #(.MIN_GAP(2)) dut (
        .clk(clk), .rst(rst), .src(src), .mask_we(mask_we), .mask_wd(mask_wd),
        .iack(iack), .irq(irq), .cause(cause), .pend(pend), .mask(mask), .in_svc(in_svc)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic e_irq, input logic [7:0] e_pend,
                       input logic [2:0] e_cause, input logic e_svc);
        exp_t e;
        e.name = name; e.irq = e_irq; e.pend = e_pend; e.mask = mask_exp;
        e.cause = e_cause; e.in_svc = e_svc;
        sb_q.push_back(e);
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        tick();
        mask_we  = 1'b0;
        mask_exp = m;
    endtask

    task automatic pulse_src(input logic [7:0] s);
        src = s;
        tick();
        src = 8'h00;
    endtask

    // Monitor: outputs are registered and settle right after posedge, so compare on negedge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (irq !== e.irq || pend !== e.pend || mask !== e.mask ||
                cause !== e.cause || in_svc !== e.in_svc) begin
                errors++;
                $display("FAIL %s: got irq=%b pend=%h mask=%h cause=%0d in_svc=%b, want irq=%b pend=%h mask=%h cause=%0d in_svc=%b",
                         e.name, irq, pend, mask, cause, in_svc,
                         e.irq, e.pend, e.mask, e.cause, e.in_svc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; src = 8'h00; mask_we = 1'b0; mask_wd = 8'h00; iack = 1'b0;
        tick(3);
        chk("reset", 1'b0, 8'h00, 3'd0, 1'b0);
        rst = 1'b1;
        tick();

        // Single source, mask all on
        write_mask(8'hFF);
        chk("mask_ff", 1'b0, 8'h00, 3'd0, 1'b0);
        pulse_src(8'h08);
        for (int j = 0; j < PL; j++) begin
            chk("src3_latency", 1'b0, 8'h00, 3'd0, 1'b0);
            tick();
        end
        chk("src3_pend", 1'b0, 8'h08, 3'd0, 1'b0);
        tick();
        chk("src3_irq", 1'b1, 8'h08, 3'd0, 1'b0);
        iack = 1'b1; tick();
        chk("src3_ack", 1'b0, 8'h00, 3'd3, 1'b1);
        iack = 1'b0; tick();
        chk("src3_gap", 1'b0, 8'h00, 3'd3, 1'b0);
        tick(2);
        chk("src3_idle", 1'b0, 8'h00, 3'd3, 1'b0);

        // Two simultaneous sources: priority then re-request after gap
        pulse_src(8'h22);
        tick(PL);
        chk("dual_pend", 1'b0, 8'h22, 3'd3, 1'b0);
        tick();
        chk("dual_irq", 1'b1, 8'h22, 3'd3, 1'b0);
        iack = 1'b1; tick();
        chk("dual_ack1", 1'b0, 8'h20, 3'd1, 1'b1);
        iack = 1'b0; tick();
        chk("dual_gap0", 1'b0, 8'h20, 3'd1, 1'b0);
        tick();
        chk("dual_gap1", 1'b0, 8'h20, 3'd1, 1'b0);
        tick();
        chk("dual_idle", 1'b0, 8'h20, 3'd1, 1'b0);
        tick();
        chk("dual_irq2", 1'b1, 8'h20, 3'd1, 1'b0);
        iack = 1'b1; tick();
        chk("dual_ack2", 1'b0, 8'h00, 3'd5, 1'b1);
        iack = 1'b0; tick(3);

        // Masked request retained, then unmasked, then withdrawn in REQ
        write_mask(8'h00);
        pulse_src(8'h04);
        tick(PL + 2);
        chk("masked_pend", 1'b0, 8'h04, 3'd5, 1'b0);
        write_mask(8'h04);
        chk("unmask_edge1", 1'b0, 8'h04, 3'd5, 1'b0);
        tick();
        chk("unmask_irq", 1'b1, 8'h04, 3'd5, 1'b0);
        write_mask(8'h00);
        tick();
        chk("withdraw", 1'b0, 8'h04, 3'd5, 1'b0);

        // Spurious ack in IDLE is ignored
        iack = 1'b1; tick();
        iack = 1'b0; tick();
        chk("spurious_ack", 1'b0, 8'h04, 3'd5, 1'b0);

        // New edge during service is latched but waits for GAP to end
        write_mask(8'hFF);
        tick();
        chk("src2_irq", 1'b1, 8'h04, 3'd5, 1'b0);
        iack = 1'b1; tick();
        chk("src2_ack", 1'b0, 8'h00, 3'd2, 1'b1);
        pulse_src(8'h01);
        tick(PL);
        chk("svc_latch", 1'b0, 8'h01, 3'd2, 1'b1);
        iack = 1'b0; tick();
        chk("svc_gap0", 1'b0, 8'h01, 3'd2, 1'b0);
        tick();
        chk("svc_gap1", 1'b0, 8'h01, 3'd2, 1'b0);
        tick();
        chk("svc_idle", 1'b0, 8'h01, 3'd2, 1'b0);
        tick();
        chk("src0_irq", 1'b1, 8'h01, 3'd2, 1'b0);
        iack = 1'b1; tick();
        chk("src0_ack", 1'b0, 8'h00, 3'd0, 1'b1);

        // Reset during SVC with src held high across it
        src = 8'h10;
        tick(PL + 1);
        chk("pre_rst_pend", 1'b0, 8'h10, 3'd0, 1'b1);
        rst = 1'b0; iack = 1'b0;
        tick();
        mask_exp = 8'h00;
        chk("mid_rst", 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick(PL + 4);
        chk("held_src", 1'b0, 8'h00, 3'd0, 1'b0);
        write_mask(8'hFF);
        tick(2);
        chk("held_src_unmask", 1'b0, 8'h00, 3'd0, 1'b0);
        src = 8'h00;
        tick(3);
        pulse_src(8'h10);
        tick(PL);
        chk("post_rst_pend", 1'b0, 8'h10, 3'd0, 1'b0);
        tick();
        chk("post_rst_irq", 1'b1, 8'h10, 3'd0, 1'b0);

        tick(2);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
